// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions the raw active-low push button for the dice core. The pin is
// brought into the CLK domain with a two-flop synchroniser. A stability
// counter then rejects contact bounce: the debounced state only flips after
// the synchronised input has disagreed with it for DB_CYCLES consecutive
// edges. The block also produces one-cycle press/release strobes and a
// long-press flag.
//
// Parameters:
//   DB_CYCLES     consecutive mismatching cycles needed to flip the debounced
//                 state (>= 2)
//   HOLD_CYCLES   cycles PRESSED must stay high before HOLD asserts (>= 1)
//
// Ports:
//   CLK            in   single rising-edge clock
//   RST_N          in   synchronous active-low reset
//   BUTTON_N       in   raw asynchronous button, 0 = pushed
//   PRESSED        out  debounced level, 1 = pushed
//   PRESS_PULSE    out  one-cycle strobe when the debounced state becomes pushed
//   RELEASE_PULSE  out  one-cycle strobe when the debounced state becomes released
//   HOLD           out  long-press flag; clears together with PRESSED
//
// All outputs come straight from flops, so there is no combinational path
// from any input to any output. Input-to-output latency is DB_CYCLES+2 edges:
// two synchroniser edges, then DB_CYCLES counting edges. The last counting
// edge flips the state and updates the outputs.
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int DB_CYCLES   = 1000000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BUTTON_N,
    output logic PRESSED,
    output logic PRESS_PULSE,
    output logic RELEASE_PULSE,
    output logic HOLD
);

    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    // Synchroniser and debounce state
    logic              r_sync1;
    logic              r_sync2;
    logic              r_stable_n;
    logic [DB_W-1:0]   r_db_cnt;

    // Hold tracking
    logic [HOLD_W-1:0] r_hold_cnt;

    // Registered outputs
    logic              r_pressed;
    logic              r_press_pulse;
    logic              r_release_pulse;
    logic              r_hold;

    // Next-state terms
    logic              w_mismatch;
    logic              w_db_done;
    logic              w_press_evt;
    logic              w_release_evt;
    logic              w_stable_n_next;
    logic [DB_W-1:0]   w_db_cnt_next;
    logic [HOLD_W-1:0] w_hold_cnt_next;

    // The debounced state flips on the edge where the counter has already
    // seen DB_CYCLES-1 mismatches and the input still disagrees. That edge is
    // mismatch number DB_CYCLES. The new value of sync2 gives the direction.
    assign w_mismatch    = (r_sync2 != r_stable_n);
    assign w_db_done     = w_mismatch && (r_db_cnt == DB_LAST);
    assign w_press_evt   = w_db_done && !r_sync2;
    assign w_release_evt = w_db_done &&  r_sync2;

    always_comb begin
        w_stable_n_next = r_stable_n;
        w_db_cnt_next   = r_db_cnt;
        if (!w_mismatch) begin
            // Any agreement, including a bounce back, restarts the count.
            w_db_cnt_next = '0;
        end else if (w_db_done) begin
            w_stable_n_next = r_sync2;
            w_db_cnt_next   = '0;
        end else begin
            w_db_cnt_next = r_db_cnt + DB_W'(1);
        end
    end

    // Hold counting uses the registered PRESSED. Counting therefore starts on
    // the edge after the press flip, and HOLD rises exactly HOLD_CYCLES edges
    // after PRESSED. The release event takes priority over counting, so HOLD
    // and PRESSED fall on the same edge.
    always_comb begin
        w_hold_cnt_next = r_hold_cnt;
        if (w_release_evt) begin
            w_hold_cnt_next = '0;
        end else if (r_pressed && (r_hold_cnt != HOLD_MAX)) begin
            w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_stable_n      <= 1'b1;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_hold          <= 1'b0;
        end else begin
            r_sync1         <= BUTTON_N;
            r_sync2         <= r_sync1;
            r_stable_n      <= w_stable_n_next;
            r_db_cnt        <= w_db_cnt_next;
            r_hold_cnt      <= w_hold_cnt_next;
            // PRESSED is registered from the next debounced state, so it
            // changes on the same edge as the flip and not one cycle later.
            r_pressed       <= ~w_stable_n_next;
            r_press_pulse   <= w_press_evt;
            r_release_pulse <= w_release_evt;
            r_hold          <= (w_hold_cnt_next == HOLD_MAX);
        end
    end

    assign PRESSED       = r_pressed;
    assign PRESS_PULSE   = r_press_pulse;
    assign RELEASE_PULSE = r_release_pulse;
    assign HOLD          = r_hold;

endmodule

// File: doc/button_debounce.md
# button_debounce

Front-end conditioning stage between the raw active-low push button and the dice core. Synchronises the asynchronous `BUTTON_N` pin and rejects contact bounce with a stability counter. Delivers a clean active-high level plus single-cycle press/release strobes and a long-press flag, which the dice logic uses to run and stop its roll counter. All outputs are registered and all logic is in the `CLK` domain.

## Interface

Parameters:
- `DB_CYCLES`, default 1000000: number of consecutive cycles the synchronised input must differ from the current debounced state before that state flips (10 ms at 100 MHz). Legal range is ≥2.
- `HOLD_CYCLES`, default 50000000: number of cycles `PRESSED` must stay high before `HOLD` asserts. Legal range is ≥1.

Ports:
- `CLK` input, 1 bit: single clock, rising-edge.
- `RST_N` input, 1 bit: reset, synchronous, active-low.
- `BUTTON_N` input, 1 bit: raw button, asynchronous, 0 = pushed.
- `PRESSED` output, 1 bit: debounced level, 1 = pushed.
- `PRESS_PULSE` output, 1 bit: one-cycle strobe on the debounced press.
- `RELEASE_PULSE` output, 1 bit: one-cycle strobe on the debounced release.
- `HOLD` output, 1 bit: long-press flag.

## Operation

- **Synchroniser.** Two flops, `sync1 <= BUTTON_N` and `sync2 <= sync1`. Both reset to 1 (released).
- **Debounce state.** `stable_n` resets to 1.
  - `db_cnt` is `$clog2(DB_CYCLES)` bits wide and resets to 0.
  - Each edge where `sync2 == stable_n`: `db_cnt <= 0`. This means any bounce back restarts the count.
  - Each edge where `sync2 != stable_n` and `db_cnt != DB_CYCLES-1`: `db_cnt <= db_cnt+1`.
  - Each edge where `sync2 != stable_n` and `db_cnt == DB_CYCLES-1`: `stable_n <= sync2` and `db_cnt <= 0`.
  - `db_cnt` never exceeds `DB_CYCLES-1`, so there is no wrap.
- **Level output.** `PRESSED` is the registered `~stable_n`.
- **Pulses.** `PRESS_PULSE` is registered high on exactly the edge where `stable_n` goes 1→0. `RELEASE_PULSE` is registered high on exactly the edge where `stable_n` goes 0→1. Each strobe is high for one cycle and then returns to 0. The two strobes are never high together.
- **Hold.**
  - `hold_cnt` is `$clog2(HOLD_CYCLES+1)` bits wide.
  - While `PRESSED`=1, `hold_cnt` increments and saturates at `HOLD_CYCLES`.
  - `HOLD` is high when `hold_cnt == HOLD_CYCLES` and stays high, without re-pulsing, until release.
  - On the release edge (`RELEASE_PULSE` cycle), `hold_cnt` and `HOLD` clear to 0.
- **Reset.** `RST_N`=0 at any edge forces all of the following on that edge, regardless of `BUTTON_N` or any operation in progress:
  - `sync1`, `sync2`, `stable_n` = 1
  - `db_cnt`, `hold_cnt` = 0
  - `PRESSED`, `PRESS_PULSE`, `RELEASE_PULSE`, `HOLD` = 0

  A button held through reset is reported as a new press once reset deasserts, after the full latency.

## Timing

- Number the first rising edge that samples a new `BUTTON_N` value as edge 1, with the input stable from then on:
  - edge 2: `sync2` updates;
  - edges 3 … DB_CYCLES+2: mismatch counting;
  - after edge DB_CYCLES+2: `PRESSED` changes and the matching pulse is high for that one cycle.
- Total input-to-output latency is DB_CYCLES+2 cycles, for both press and release.
- A glitch shorter than DB_CYCLES cycles, measured at `sync2`, produces no output change.
- `HOLD` rises HOLD_CYCLES cycles after `PRESSED` rises.
- `HOLD` falls in the same cycle that `PRESSED` falls.
- There is no combinational path from any input to any output.

## Test plan

Bench parameters: `DB_CYCLES`=8, `HOLD_CYCLES`=32, 10 ns clock.

1. **Reset.** Hold `RST_N`=0 for 3 cycles with `BUTTON_N`=0 → all outputs 0. Release reset → `PRESSED`=1 and `PRESS_PULSE`=1 for one cycle, exactly 10 edges after the first edge sampled with `RST_N`=1.
2. **Clean press and release.** `BUTTON_N` 1→0 and held for 100 cycles, then 0→1:
   - `PRESSED` rises after edge 10 of the press, with exactly one `PRESS_PULSE`;
   - `PRESSED` falls 10 edges after the release, with exactly one `RELEASE_PULSE`;
   - pulse counts are 1 and 1.
3. **Bounce.** `BUTTON_N` toggles with low runs of 1, 3, 7 and 7 cycles separated by 2-cycle high runs, then goes low and stays low → `PRESSED` stays 0 through the bounce. It rises 10 edges after the start of the final low run, with no extra pulses.
4. **Long press.** Hold for 60 cycles after `PRESSED` rises → `HOLD` rises 32 cycles after `PRESSED`. On release, `HOLD` and `PRESSED` fall in the same cycle, and `HOLD` never toggles while held.
5. **Short press.** Hold for exactly 20 debounced cycles → `HOLD` never asserts and `hold_cnt` returns to 0 after release.
6. **Reset mid-operation.** Assert `RST_N`=0 for one cycle while `db_cnt`=5 during a release, and separately while `HOLD`=1 → all outputs 0 on that edge. Recovery then follows the scenario 1 latency when `BUTTON_N`=0 is still held.
